// File: rtl/frame_stream_source.sv
// frame_stream_source: raster-scan pixel transmitter that streams a frame from memory into the window buffer.
// Define FRAME_STREAM_FLUSH_EN to append flushRows rows of fillValue pixels after the frame.
module frame_stream_source #(
    parameter int imCol = 1024,
    parameter int imRow = 768,
    parameter int bitwidth = 8,
    parameter int addrBits = 20,
    parameter int flushRows = 24,
    parameter logic [bitwidth-1:0] fillValue = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addrBits-1:0]   base_addr,
    input  logic                  hold,
    output logic                  mem_rd,
    output logic [addrBits-1:0]   mem_addr,
    input  logic [bitwidth-1:0]   mem_data,
    output logic [bitwidth-1:0]   dataOut,
    output logic                  enable,
    output logic [(imCol > 1 ? $clog2(imCol) : 1)-1:0] pix_col,
    output logic [(imRow + flushRows > 1 ? $clog2(imRow + flushRows) : 1)-1:0] pix_row,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = imCol > 1 ? $clog2(imCol) : 1;
    localparam int RW = imRow + flushRows > 1 ? $clog2(imRow + flushRows) : 1;
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3;

    logic [1:0]          state;
    logic [addrBits-1:0] addr;
    logic [CW-1:0]       col, s1_col;
    logic [RW-1:0]       row, s1_row;
    logic                s1_valid, s1_fill;
    logic                accept, issue, fill_issue, col_last, last_data, last_fill;

    assign col_last  = col == CW'(imCol - 1);
    assign last_data = col_last && row == RW'(imRow - 1);
`ifdef FRAME_STREAM_FLUSH_EN
    assign fill_issue = state == FLUSH && !hold;
    assign last_fill  = col_last && row == RW'(imRow + flushRows - 1);
`else
    assign fill_issue = 1'b0;
    assign last_fill  = 1'b0;
`endif
    assign mem_rd   = state == READ && !hold;
    assign mem_addr = addr;
    assign issue    = mem_rd || fill_issue;
    // frame_done is checked so a start landing in the completion cycle is dropped
    assign accept   = state == IDLE && start && !frame_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            col        <= '0;
            row        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                addr  <= base_addr;
                col   <= '0;
                row   <= '0;
                busy  <= 1'b1;
                state <= READ;
            end else if (issue) begin
                col <= col_last ? '0 : col + 1'b1;
                row <= col_last ? row + 1'b1 : row;
                if (mem_rd)
                    addr <= addr + 1'b1;
`ifdef FRAME_STREAM_FLUSH_EN
                if (mem_rd && last_data)
                    state <= FLUSH;
                if (fill_issue && last_fill)
                    state <= DRAIN;
`else
                if (mem_rd && last_data)
                    state <= DRAIN;
`endif
            end else if (state == DRAIN && !s1_valid) begin
                // the last pixel leaves the output register this cycle
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
            end
        end
    end

    // stage 1 tags the issued pixel while memory reads; the output register takes the read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fill  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            enable   <= 1'b0;
            dataOut  <= '0;
            pix_col  <= '0;
            pix_row  <= '0;
        end else begin
            s1_valid <= issue;
            s1_fill  <= fill_issue;
            if (issue) begin
                s1_col <= col;
                s1_row <= row;
            end
            enable <= s1_valid;
            if (s1_valid) begin
                dataOut <= s1_fill ? fillValue : mem_data;
                pix_col <= s1_col;
                pix_row <= s1_row;
            end
        end
    end
endmodule

// File: tb/tb_frame_stream_source.sv
// tb_frame_stream_source: table-driven frame checks plus reset and hold corner sequences.
// Expected totals follow FRAME_STREAM_FLUSH_EN.
module tb_frame_stream_source;
    localparam int IC = 4, IR = 3, FR = 2, AB = 8;
    localparam int NRD = IR * IC;
`ifdef FRAME_STREAM_FLUSH_EN
    localparam int NTOT = (IR + FR) * IC;
`else
    localparam int NTOT = IR * IC;
`endif

    typedef struct {
        logic [7:0] base;
        int         hold_after;
        int         hold_len;
        int         busy_start;
        bit         start_on_done;
        int         exp_strobes;
    } vec_t;

    logic          clock = 0, reset = 0, start = 0, hold = 0;
    logic [AB-1:0] base_addr = '0;
    logic          mem_rd, enable, busy, frame_done;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_data = '0, dataOut;
    logic [1:0]    pix_col;
    logic [2:0]    pix_row;
    int            checks = 0, failures = 0;
    vec_t          vecs[5];

    frame_stream_source #(.imCol(IC), .imRow(IR), .bitwidth(8), .addrBits(AB),
                          .flushRows(FR), .fillValue(8'hFF)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .hold(hold),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .dataOut(dataOut),
        .enable(enable), .pix_col(pix_col), .pix_row(pix_row), .busy(busy),
        .frame_done(frame_done));

    always #5 clock = ~clock;

    // memory word = address low byte, one cycle after the read strobe
    always @(posedge clock) mem_data <= mem_rd ? mem_addr : 8'hEE;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int cyc = 0, rd = 0, k = 0, rd0 = -1, last_en = -1, hold_left = v.hold_len, hold_age = 0;
        bit done = 0;
        @(negedge clock);
        start = 1;
        base_addr = v.base;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (mem_rd) begin
                chk("rd_addr", int'(mem_addr), int'(8'(v.base + rd)));
                chk("rd_beyond_frame", int'(rd < NRD), 1);
                if (rd0 < 0) rd0 = cyc;
                rd++;
            end
            chk("rd_in_hold", int'(mem_rd && hold), 0);
            hold_age = hold ? hold_age + 1 : 0;
            if (enable) begin
                chk("en_in_hold", int'(hold_age >= 3), 0);
                chk("data", int'(dataOut), k < NRD ? int'(8'(v.base + k)) : 255);
                chk("col", int'(pix_col), k % IC);
                chk("row", int'(pix_row), k / IC);
                if (k == 0) chk("latency", cyc - rd0, 2);
                k++;
                last_en = cyc;
            end
            if (frame_done) begin
                chk("strobes", k, v.exp_strobes);
                chk("reads", rd, NRD);
                chk("done_timing", cyc - last_en, 1);
                chk("busy_at_done", int'(busy), 0);
                done = 1;
            end else begin
                chk("busy", int'(busy), 1);
            end
            start = done ? v.start_on_done : (cyc == v.busy_start);
            if (start) base_addr = 8'h55;
            hold = !done && v.hold_after > 0 && rd >= v.hold_after && hold_left > 0;
            if (hold) hold_left--;
        end
        if (!done) chk("frame_timeout", 0, 1);
        @(negedge clock);
        start = 0;
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle_busy", int'(busy), 0);
            chk("idle_en", int'(enable), 0);
            chk("idle_rd", int'(mem_rd), 0);
        end
    endtask

    initial begin
        vecs[0] = '{8'd16,  0,  0, -1, 1'b0, NTOT};
        vecs[1] = '{8'd40,  5,  3, -1, 1'b0, NTOT};
        vecs[2] = '{8'd100, 0,  0,  3, 1'b1, NTOT};
        vecs[3] = '{8'd254, 0,  0, -1, 1'b0, NTOT};
        vecs[4] = '{8'd200, 11, 2,  6, 1'b1, NTOT};

        repeat (2) @(negedge clock);
        chk("rst_en", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(mem_rd), 0);
        chk("rst_done", int'(frame_done), 0);
        reset = 1;

        // asynchronous reset in the middle of a streaming frame
        @(negedge clock);
        start = 1;
        base_addr = 8'd16;
        @(negedge clock);
        start = 0;
        repeat (4) @(negedge clock);
        chk("pre_rst_en", int'(enable), 1);
        #2 reset = 0;
        #1;
        chk("mid_rst_en", int'(enable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rd", int'(mem_rd), 0);
        chk("mid_rst_data", int'(dataOut), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("post_rst_en", int'(enable), 0);
            chk("post_rst_rd", int'(mem_rd), 0);
            chk("post_rst_busy", int'(busy), 0);
        end

        for (int i = 0; i < 5; i++) run(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Raster-scan pixel transmitter that drives the pixel-stream input (dataIn/enable) of the scan-line window buffer.
- On a start pulse, reads one imRow x imCol frame from a synchronous-read frame memory in row-major order and emits one pixel per enable strobe.
- Optionally appends flush pixels so the last window rows reach the buffer output.
- Honours a downstream hold; signals frame completion.

Parameters:
- imCol, 1024, image width in pixels
- imRow, 768, image height in pixels
- bitwidth, 8, pixel width in bits
- addrBits, 20, frame memory address width
- flushRows, 24, rows of fill pixels appended after the frame (only with the macro)
- fillValue, 0, pixel value emitted during flush

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin a frame
- base_addr  in  addrBits  frame base address, sampled when start is accepted
- hold  in  1  downstream stall; 1 = issue no new pixel this cycle
- mem_rd  out  1  memory read strobe
- mem_addr  out  addrBits  memory read address
- mem_data  in  bitwidth  read data, valid exactly 1 cycle after mem_rd
- dataOut  out  bitwidth  pixel to the window buffer
- enable  out  1  1-cycle strobe qualifying dataOut
- pix_col  out  log2(imCol)  column of pixel on dataOut
- pix_row  out  log2(imRow+flushRows)  row of pixel on dataOut
- busy  out  1  frame in progress
- frame_done  out  1  1-cycle pulse when the frame is fully emitted

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, counters 0, pipeline emptied; takes effect immediately mid-frame, and no stale enable is emitted after release.
- FSM states: IDLE, READ, FLUSH, DRAIN.
- IDLE:
  - start=1: latch base_addr into the address counter; clear col/row; set busy=1 on the next edge; go to READ.
  - start while busy is ignored.
- READ: each cycle with hold=0, assert mem_rd with mem_addr=current address, then advance.
  - col wraps imCol-1 -> 0 and increments row.
  - Address increments by 1, modulo 2^addrBits; wrap is permitted, not flagged.
  - Issuing pixel (imRow-1, imCol-1) goes to FLUSH (macro on) or DRAIN (macro off).
  - hold=1: mem_rd=0; address/counters frozen.
- FLUSH: each cycle with hold=0, issue one fill pixel with no memory read.
  - Row continues imRow .. imRow+flushRows-1.
  - Issuing the last fill pixel goes to DRAIN.
- DRAIN: wait until the 2-stage pipeline is empty, then pulse frame_done=1 for one cycle, busy=0, go to IDLE.
  - A start in the frame_done cycle is ignored.
- Pipeline (fixed latency 2 from issue to enable):
  - Issue at cycle t (mem_rd or fill).
  - Stage 1 at t+1 captures mem_data (or fillValue) plus col/row tags.
  - At t+2, registered dataOut/pix_col/pix_row update and enable=1 for one cycle.
  - dataOut, pix_col and pix_row hold their last value when enable=0.
- Hold semantics: hold gates issue only. Pixels already in flight (up to 2) still emerge, so the downstream must accept 2 strobes after raising hold.
- Exactly imRow*imCol (+flushRows*imCol with the macro) enable strobes per frame; never more than one per cycle.

Optional Feature:
- Macro: FRAME_STREAM_FLUSH_EN.
- Defined: FLUSH state present; flushRows*imCol pixels of fillValue follow the frame, so the final window rows of the window buffer become valid.
- Undefined: FLUSH state and flush logic absent; READ goes directly to DRAIN; flushRows and fillValue unused; pix_row max imRow-1.

Test Plan (imCol=4, imRow=3, flushRows=2, fillValue=8'hFF, memory word = address low byte):
- Reset 0 mid-READ with enable toggling -> enable, busy, mem_rd go 0 immediately; after release there are no strobes until a new start.
- start with base_addr=16, hold=0, macro off -> mem_rd for addresses 16..27 on consecutive cycles; enable for 12 consecutive cycles starting 2 cycles after the first mem_rd; dataOut 16..27; pix_col/pix_row 0..3/0..2; frame_done 1 cycle after the last strobe.
- Same frame, macro on -> 12 data strobes then 8 strobes of 8'hFF with pix_row 3,4; mem_rd never asserted during flush; 20 strobes total.
- hold=1 for 3 cycles after the 5th mem_rd -> at most 2 further enables, then none; resumes at address base+5 with no pixel lost or duplicated.
- start pulsed while busy and in the frame_done cycle -> ignored: no address re-latch, strobe count unchanged.
- base_addr=2^addrBits-2 -> addresses wrap to 0 and continue; frame completes normally.
